// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: valid/ready handshake, flush, stall/flush counters.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer that registers in_ready_o.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam entry_t EMPTY = '0;

    entry_t           main_q, main_d;
    entry_t           in_entry;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             in_fire;
    logic             out_fire;

    assign in_entry    = {1'b1, in_ctrl_i, in_data_i};
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;

    assign out_valid_o = main_q.valid;
    assign out_data_o  = main_q.data;
    // An empty stage must look like a NOP to whoever consumes out_ctrl_o.
    assign out_ctrl_o  = main_q.valid ? main_q.ctrl : '0;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

`ifdef PIPE_STAGE_SKID_EN
    entry_t skid_q, skid_d;

    // Ready comes from skid state only; flush always swallows the offered beat.
    assign in_ready_o = ~skid_q.valid | flush_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        main_d = main_q;
        skid_d = skid_q;
        if (flush_i) begin
            main_d = EMPTY;
            skid_d = EMPTY;
        end else if (!main_q.valid) begin
            if (in_fire) main_d = in_entry;
        end else if (out_fire) begin
            if (skid_q.valid) begin
                main_d       = skid_q;
                skid_d.valid = 1'b0;
            end else if (in_fire) begin
                main_d = in_entry;
            end else begin
                main_d.valid = 1'b0;
            end
        end else if (in_fire) begin
            skid_d = in_entry;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) skid_q <= EMPTY;
        else         skid_q <= skid_d;
    end
`else
    assign in_ready_o = ~main_q.valid | out_ready_i | flush_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        main_d = main_q;
        if (flush_i)       main_d       = EMPTY;
        else if (in_fire)  main_d       = in_entry;
        else if (out_fire) main_d.valid = 1'b0;
    end
`endif

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid_o && !out_ready_i && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_i && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments; data payload is reset too
    // so out_data_o reads 0 after reset rather than X.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            main_q      <= EMPTY;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            main_q      <= main_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed, table-driven bench for pipe_stage_reg (default and PIPE_STAGE_SKID_EN builds).
module tb_pipe_stage_reg;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] in_data_i;
    logic [15:0] in_ctrl_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] out_data_o;
    logic [15:0] out_ctrl_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [63:0] s_out_data;
    logic [15:0] s_out_ctrl;
    logic [3:0]  s_stall_cnt;
    logic [3:0]  s_flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .CNT_W(16)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .in_ctrl_i(in_ctrl_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_ctrl_o(out_ctrl_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(16), .CNT_W(4)) dut_sat (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(s_in_ready),
        .in_data_i(in_data_i), .in_ctrl_i(in_ctrl_i),
        .out_valid_o(s_out_valid), .out_ready_i(out_ready_i),
        .out_data_o(s_out_data), .out_ctrl_o(s_out_ctrl),
        .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    typedef struct {
        logic        flush;
        logic        in_valid;
        logic [15:0] in_ctrl;
        logic        out_ready;
        logic        exp_ready;
        logic        exp_valid;
        logic [15:0] exp_ctrl;
        logic        chk_data;
        logic [15:0] exp_stall;
        logic [15:0] exp_flush;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fl, input logic iv, input logic [15:0] ic,
                                input logic orr, input logic er, input logic ev,
                                input logic [15:0] ec, input logic cd,
                                input logic [15:0] es, input logic [15:0] ef);
        vec_t v;
        v.flush = fl; v.in_valid = iv; v.in_ctrl = ic; v.out_ready = orr;
        v.exp_ready = er; v.exp_valid = ev; v.exp_ctrl = ec; v.chk_data = cd;
        v.exp_stall = es; v.exp_flush = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [15:0] ic, input logic orr);
        flush_i     = fl;
        in_valid_i  = iv;
        in_ctrl_i   = ic;
        in_data_i   = {4{ic}};
        out_ready_i = orr;
    endtask

    initial begin
        reset_i = 1'b1;
        drive(1'b0, 1'b1, 16'h0BAD, 1'b0);

        // Reset state, with a beat offered during reset.
        tick();
        tick();
        check("rst out_valid", out_valid_o, 0);
        check("rst out_data", out_data_o, 0);
        check("rst out_ctrl", out_ctrl_o, 0);
        check("rst stall_cnt", stall_cnt_o, 0);
        check("rst flush_cnt", flush_cnt_o, 0);
        check("rst in_ready", in_ready_o, 1);
        reset_i = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        tick();
        check("rst beat discarded", out_valid_o, 0);

        // Streaming.
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 1, 16'(i), 1, 1, 1, 16'(i), 1, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 0, 0));
        // Stall with main holding 0x00A5.
        vecs.push_back(mk(0, 1, 16'h00A5, 1, 1, 1, 16'h00A5, 1, 0, 0));
`ifdef PIPE_STAGE_SKID_EN
        vecs.push_back(mk(0, 1, 16'h00B1, 0, 1, 1, 16'h00A5, 1, 1, 0));
        vecs.push_back(mk(0, 1, 16'h00B2, 0, 0, 1, 16'h00A5, 1, 2, 0));
        vecs.push_back(mk(0, 1, 16'h00B2, 0, 0, 1, 16'h00A5, 1, 3, 0));
        vecs.push_back(mk(0, 1, 16'h00B2, 1, 0, 1, 16'h00B1, 1, 3, 0));
        vecs.push_back(mk(0, 1, 16'h00B2, 1, 1, 1, 16'h00B2, 1, 3, 0));
`else
        vecs.push_back(mk(0, 1, 16'h00B1, 0, 0, 1, 16'h00A5, 1, 1, 0));
        vecs.push_back(mk(0, 1, 16'h00B1, 0, 0, 1, 16'h00A5, 1, 2, 0));
        vecs.push_back(mk(0, 1, 16'h00B1, 0, 0, 1, 16'h00A5, 1, 3, 0));
        vecs.push_back(mk(0, 1, 16'h00B1, 1, 1, 1, 16'h00B1, 1, 3, 0));
        vecs.push_back(mk(0, 1, 16'h00B2, 1, 1, 1, 16'h00B2, 1, 3, 0));
`endif
        vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 3, 0));
        // Flush while full and stalled; offered 0x1234 must vanish.
        vecs.push_back(mk(0, 1, 16'hFFFF, 1, 1, 1, 16'hFFFF, 1, 3, 0));
        vecs.push_back(mk(1, 1, 16'h1234, 0, 1, 0, 16'h0000, 1, 4, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 1, 4, 1));
        // Flush coinciding with output fire of 0x0042.
        vecs.push_back(mk(0, 1, 16'h0042, 1, 1, 1, 16'h0042, 1, 4, 1));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 0, 16'h0000, 1, 4, 2));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 1, 4, 2));

        foreach (vecs[i]) begin
            drive(vecs[i].flush, vecs[i].in_valid, vecs[i].in_ctrl, vecs[i].out_ready);
            #1;
            check($sformatf("v%0d in_ready", i), in_ready_o, vecs[i].exp_ready);
            tick();
            check($sformatf("v%0d out_valid", i), out_valid_o, vecs[i].exp_valid);
            check($sformatf("v%0d out_ctrl", i), out_ctrl_o, vecs[i].exp_ctrl);
            if (vecs[i].chk_data)
                check($sformatf("v%0d out_data", i), out_data_o, {4{vecs[i].exp_ctrl}});
            check($sformatf("v%0d stall_cnt", i), stall_cnt_o, vecs[i].exp_stall);
            check($sformatf("v%0d flush_cnt", i), flush_cnt_o, vecs[i].exp_flush);
        end

        // Saturation: both instances start this section at stall count 4.
        drive(1'b0, 1'b1, 16'h00C3, 1'b1);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("sat%0d stall_cnt4", k), s_stall_cnt, (4 + k > 15) ? 15 : 4 + k);
        end
        check("sat stall_cnt16", stall_cnt_o, 24);
        check("sat flush_cnt4", s_flush_cnt, 2);
        check("sat held ctrl", out_ctrl_o, 16'h00C3);

        // Asynchronous reset while stalled (skid also filled in the skid build).
        drive(1'b0, 1'b1, 16'h00D4, 1'b0);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        reset_i = 1'b1;
        #1;
        check("arst out_valid", out_valid_o, 0);
        check("arst out_ctrl", out_ctrl_o, 0);
        check("arst out_data", out_data_o, 0);
        check("arst stall_cnt", stall_cnt_o, 0);
        check("arst flush_cnt", flush_cnt_o, 0);
        check("arst stall_cnt4", s_stall_cnt, 0);
        check("arst in_ready", in_ready_o, 1);
        #1;
        reset_i = 1'b0;
        drive(1'b0, 1'b1, 16'h0077, 1'b1);
        tick();
        check("post-rst out_valid", out_valid_o, 1);
        check("post-rst out_ctrl", out_ctrl_o, 16'h0077);
        check("post-rst out_data", out_data_o, {4{16'h0077}});
        check("post-rst stall_cnt", stall_cnt_o, 0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        tick();
        check("post-rst drained", out_valid_o, 0);
        check("post-rst no ctrl", out_ctrl_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, parametrised pipeline stage register for the pipelined datapath, replacing the per-stage hand-written IF/ID, ID/EX, EX/MEM and MEM/WB registers. It carries a data bundle and a control bundle across one stage boundary with a valid/ready handshake. It also supports stall (downstream back-pressure), synchronous flush (bubble insertion) and saturating stall/flush event counters. An optional skid entry breaks the combinational ready path.

## Interface
Parameters:
- DATA_W, 64, width of the data bundle (operands, immediates, register indices, packed by the instantiating stage)
- CTRL_W, 16, width of the control bundle (write enables, mux selects); all-zero encodes a NOP
- CNT_W, 16, width of each event counter

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- reset_i  input  1  reset, asynchronous, active-high
- flush_i  input  1  synchronous flush; inserts a bubble
- in_valid_i  input  1  upstream beat valid
- in_ready_o  output  1  stage can accept a beat this cycle
- in_data_i  input  DATA_W  upstream data bundle
- in_ctrl_i  input  CTRL_W  upstream control bundle
- out_valid_o  output  1  held beat valid
- out_ready_i  input  1  downstream accepts this cycle (0 = stall)
- out_data_o  output  DATA_W  held data bundle
- out_ctrl_o  output  CTRL_W  held control bundle, forced to 0 when out_valid_o=0
- stall_cnt_o  output  CNT_W  cycles with out_valid_o=1 and out_ready_i=0, saturating
- flush_cnt_o  output  CNT_W  cycles with flush_i=1, saturating

## Operation
- Main entry: main_valid, main_data, main_ctrl. Input fire = in_valid_i & in_ready_o. Output fire = out_valid_o & out_ready_i.
- Without skid: in_ready_o = !main_valid | out_ready_i. On input fire, main is loaded. On output fire without input fire, main_valid is cleared.
- out_ctrl_o = main_valid ? main_ctrl : 0, so a stalled-empty or flushed stage always presents a NOP to the downstream stage.
- Flush (highest priority after reset):
  - In the flush cycle, main_valid and the skid valid clear, and main_data and main_ctrl load 0.
  - in_ready_o is 1 during flush, and any upstream beat offered in that cycle is consumed and discarded.
- Counters:
  - stall_cnt_o increments in each cycle with out_valid_o=1 and out_ready_i=0.
  - flush_cnt_o increments in each cycle with flush_i=1.
  - Both saturate at 2^CNT_W-1, do not wrap, and are not cleared by flush.
- Reset: main_valid, skid valid, main_data, main_ctrl, skid contents and both counters are 0.
  - Resulting outputs: out_valid_o=0, out_data_o=0, out_ctrl_o=0, stall_cnt_o=0, flush_cnt_o=0.
  - in_ready_o is 1 while reset_i is asserted. A beat offered during reset is discarded.
- Reset mid-transfer drops both entries; no partial beat survives.

## Timing
- Latency is 1 cycle: a beat accepted on edge N appears at out_* after edge N.
- Throughput is one beat per cycle while out_ready_i=1.
- Data on out_* is stable from the edge after acceptance until the edge where output fire occurs.
- Without skid, in_ready_o depends combinationally on out_ready_i.
- Simultaneous input fire and output fire with main full: main is replaced by the new beat, with no bubble.
- A flush in the same cycle as output fire: the downstream stage still consumes the current beat, and the register is empty afterwards.

## Configuration
- PIPE_STAGE_SKID_EN defined: adds a one-entry skid buffer.
  - in_ready_o = !skid_valid, driven from a flop with no combinational path from out_ready_i.
  - If input fire occurs while main is full and out_ready_i=0, the beat goes to skid.
  - On the next output fire, main loads from skid and skid clears.
  - Ordering is preserved, and throughput stays at one beat per cycle after a stall is released.
- PIPE_STAGE_SKID_EN undefined: no skid storage, and the combinational in_ready_o described under Operation applies.

## Test plan
- Streaming: out_ready_i=1; beats ctrl=0x0001..0x0008 presented on consecutive cycles -> each beat appears 1 cycle later in order, stall_cnt_o stays 0.
- Stall: hold out_ready_i=0 for 3 cycles with main holding ctrl=0x00A5 -> out_* holds 0x00A5 and stall_cnt_o=3.
  - Without skid, in_ready_o=0 for those 3 cycles.
  - With skid, exactly one extra beat is accepted, then in_ready_o=0.
  - After release, all beats emerge in order with no loss or duplication.
- Flush: flush_i=1 for one cycle while main is valid (ctrl=0xFFFF) and upstream offers ctrl=0x1234 -> next cycle out_valid_o=0, out_ctrl_o=0, out_data_o=0, flush_cnt_o=1, and 0x1234 never appears.
- Simultaneous flush and output fire: beat ctrl=0x0042 is consumed by the downstream stage in the flush cycle, and the register is empty the following cycle.
- Saturation: CNT_W=4; hold a stall for 20 cycles -> stall_cnt_o reaches 15 and stays at 15.
- Asynchronous reset mid-stall (main and skid full): reset_i pulsed between edges -> outputs and counters go to 0 immediately, without waiting for a clock edge. The first beat after release passes with 1-cycle latency.
